// File: rtl/ippcrc_crc32_chk8.sv
// ippcrc_crc32_chk8 -- receive-side CRC-32 (IEEE 802.3) checker, 8-bit datapath.
// Accumulates CRC over the whole frame including FCS, checks the fixed residue,
// reports good/crcerr/runt/abort plus length per frame, and forwards the bytes.
// Build option: IPPCRC_CHK_STRIP_EN strips the 4 FCS bytes from the forwarded stream.
module ippcrc_crc32_chk8 #(
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_vld,
  input  logic             din_sop,
  input  logic             din_eop,
  output logic [7:0]       dout,
  output logic             dout_vld,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             chk_vld,
  output logic             chk_ok,
  output logic             chk_crcerr,
  output logic             chk_runt,
  output logic             chk_abort,
  output logic [LEN_W-1:0] chk_len
);

  localparam logic [31:0]      POLY     = 32'h04C1_1DB7;
  localparam logic [31:0]      RESIDUE  = 32'hC704_DD7B;
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);

  typedef enum logic {IDLE, FRAME} state_t;

  typedef struct packed {
    logic             ok;
    logic             crcerr;
    logic             runt;
    logic             abort;
    logic [LEN_W-1:0] len;
  } stat_t;

  // a 1-byte frame can never carry a valid FCS and is always short
  localparam stat_t ONE_STAT = '{ok: 1'b0, crcerr: 1'b1, runt: 1'b1, abort: 1'b0, len: LEN_W'(1)};

  state_t           state, state_nxt;
  logic [31:0]      crc, crc_nxt, crc_upd;
  logic [LEN_W-1:0] len, len_nxt, len_inc;
  stat_t            stat, stat_nxt;
  logic             stat_ld, pend_one, pend_nxt;
  logic             accept, ev_abort, ev_one, ev_end;

  // MSB-first register; din[0] is the first line bit, so it meets crc[31] first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  assign accept   = din_vld & (din_sop | (state == FRAME));
  assign ev_abort = din_vld & din_sop & (state == FRAME);
  assign ev_one   = din_vld & din_sop & din_eop;
  assign ev_end   = din_vld & din_eop & ~din_sop & (state == FRAME);
  assign crc_upd  = crc_byte(din_sop ? CRC_INIT : crc, din);
  assign len_inc  = (len == LEN_MAX) ? len : len + 1'b1;

  // frame tracking: crc/length advance only on accepted bytes; sop restarts both
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    len_nxt   = len;
    if (accept) begin
      state_nxt = din_eop ? IDLE : FRAME;
      crc_nxt   = din_eop ? CRC_INIT : crc_upd;
      len_nxt   = din_eop ? '0 : (din_sop ? LEN_W'(1) : len_inc);
    end
  end

  // status selection; a 1-byte frame that also aborts the previous one is deferred a cycle
  always_comb begin
    stat_nxt = stat;
    stat_ld  = 1'b0;
    pend_nxt = 1'b0;
    if (pend_one) begin
      stat_nxt = ONE_STAT;
      stat_ld  = 1'b1;
      pend_nxt = ev_one;
    end else if (ev_abort) begin
      stat_nxt.ok     = 1'b0;
      stat_nxt.crcerr = 1'b0;
      stat_nxt.runt   = (len < MIN_L);
      stat_nxt.abort  = 1'b1;
      stat_nxt.len    = len;
      stat_ld         = 1'b1;
      pend_nxt        = ev_one;
    end else if (ev_end) begin
      stat_nxt.crcerr = (crc_upd != RESIDUE);
      stat_nxt.runt   = (len_inc < MIN_L);
      stat_nxt.abort  = 1'b0;
      stat_nxt.ok     = ~stat_nxt.crcerr & ~stat_nxt.runt;
      stat_nxt.len    = len_inc;
      stat_ld         = 1'b1;
    end else if (ev_one) begin
      stat_nxt = ONE_STAT;
      stat_ld  = 1'b1;
    end
  end

  // frame state, crc, length and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc      <= CRC_INIT;
      len      <= '0;
      stat     <= '0;
      chk_vld  <= 1'b0;
      pend_one <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      len      <= len_nxt;
      stat     <= stat_nxt;
      chk_vld  <= stat_ld;
      pend_one <= pend_nxt;
    end
  end

  assign chk_ok     = stat.ok;
  assign chk_crcerr = stat.crcerr;
  assign chk_runt   = stat.runt;
  assign chk_abort  = stat.abort;
  assign chk_len    = stat.len;

`ifdef IPPCRC_CHK_STRIP_EN
  logic [3:0][7:0] dline;
  logic [2:0]      fill;
  logic            first;

  // 4-byte delay line holds back the FCS; a byte leaves only when pushed out by a 5th
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dline    <= '0;
      fill     <= '0;
      first    <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      if (accept) begin
        dline <= {dline[2:0], din};
        if (din_sop) begin
          fill  <= din_eop ? 3'd0 : 3'd1;
          first <= 1'b1;
        end else if (fill == 3'd4) begin
          dout     <= dline[3];
          dout_vld <= 1'b1;
          dout_sop <= first;
          dout_eop <= din_eop;
          first    <= 1'b0;
          fill     <= din_eop ? 3'd0 : 3'd4;
        end else begin
          fill <= din_eop ? 3'd0 : fill + 3'd1;
        end
      end
    end
  end
`else
  // every accepted byte forwarded one cycle later, FCS included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= accept;
      dout_sop <= accept & din_sop;
      dout_eop <= accept & din_eop;
      if (accept) dout <= din;
    end
  end
`endif

endmodule
